// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pad-bus arbiter.
package uio_arb_pkg;

  localparam int UIO_W = 8;
  localparam int ID_W  = 3;

  localparam logic [UIO_W-1:0] OE_DRIVE   = 8'hFF;
  localparam logic [UIO_W-1:0] OE_RELEASE = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    TURN_IN,
    OWN,
    TURN_OUT
  } arb_state_e;

endpackage

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Round-robin winner selection: rotate requests so ptr sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_pick
  import uio_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    winner_o
);

  localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    enc;
  logic [ID_W:0]      sum;

  always_comb begin
    rot = NUM_REQ'({req_i, req_i} >> ptr_i);
    enc = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = ID_W'(i);
    end
    sum = {1'b0, enc} + {1'b0, ptr_i};
    if (sum >= NREQ) sum = sum - NREQ;
    valid_o  = |req_i;
    winner_o = sum[ID_W-1:0];
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared uio pad bus with turnaround gaps around
// every ownership and a hold-time limit that pre-empts slow requesters.
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   dir,
  input  logic [8*NUM_REQ-1:0] wdata,
  input  logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   grant,
  output logic [ID_W-1:0]      owner_id,
  output logic [UIO_W-1:0]     rdata,
  output logic                 preempt,
  output logic                 busy,
  input  logic [UIO_W-1:0]     uio_in,
  output logic [UIO_W-1:0]     uio_out,
  output logic [UIO_W-1:0]     uio_oe
);

  localparam logic [2:0]      CNT_INIT  = 3'(TURNAROUND - 1);
  localparam logic [7:0]      HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  arb_state_e       state_q;
  logic [ID_W-1:0]  owner_q;
  logic [ID_W-1:0]  rrPtr_q;
  logic [2:0]       cnt_q;
  logic [7:0]       hold_q;
  logic [UIO_W-1:0] rdata_q;
  logic             preempt_q;
  logic             ownDir_q;

  // Widened copies so an owner index can select without width games.
  logic [7:0]       reqPad;
  logic [7:0]       dirPad;
  logic [7:0]       donePad;
  logic [8*UIO_W-1:0] wdataPad;
  logic             ownReq;
  logic             ownDone;
  logic             pickValid;
  logic [ID_W-1:0]  pickId;
  logic [ID_W-1:0]  nextPtr;

  assign reqPad   = 8'(req);
  assign dirPad   = 8'(dir);
  assign donePad  = 8'(done);
  assign wdataPad = (8*UIO_W)'(wdata);
  assign ownReq   = reqPad[owner_q];
  assign ownDone  = donePad[owner_q];
  assign nextPtr  = (owner_q == LAST_ID) ? '0 : owner_q + ID_W'(1);

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i    (req),
    .ptr_i    (rrPtr_q),
    .valid_o  (pickValid),
    .winner_o (pickId)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rrPtr_q   <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      rdata_q   <= '0;
      preempt_q <= 1'b0;
      ownDir_q  <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      ownDir_q  <= dirPad[owner_q];
      if (state_q == OWN && !dirPad[owner_q]) rdata_q <= uio_in;
      case (state_q)
        IDLE: begin
          if (ena && pickValid) begin
            owner_q <= pickId;
            cnt_q   <= CNT_INIT;
            state_q <= TURN_IN;
          end
        end
        TURN_IN: begin
          if (!ena) begin
            state_q <= TURN_OUT;
            rrPtr_q <= nextPtr;
            cnt_q   <= CNT_INIT;
          end else if (cnt_q == 3'd0) begin
            state_q <= OWN;
            hold_q  <= '0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        OWN: begin
          hold_q <= hold_q + 8'd1;
          // Only a pure timeout is a pre-emption; done, req drop or ena win.
          if (!ena || ownDone || !ownReq || hold_q == HOLD_LAST) begin
            state_q   <= TURN_OUT;
            rrPtr_q   <= nextPtr;
            cnt_q     <= CNT_INIT;
            preempt_q <= ena && ownReq && !ownDone;
          end
        end
        TURN_OUT: begin
          if (cnt_q == 3'd0) state_q <= IDLE;
          else cnt_q <= cnt_q - 3'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = (state_q == OWN) && (owner_q == ID_W'(i));
    end
  end

  assign uio_oe   = (state_q == OWN && ownDir_q) ? OE_DRIVE : OE_RELEASE;
  assign uio_out  = (state_q == OWN && ownDir_q) ? wdataPad[{owner_q, 3'b000} +: 8] : '0;
  assign busy     = (state_q != IDLE);
  assign owner_id = owner_q;
  assign rdata    = rdata_q;
  assign preempt  = preempt_q;

endmodule
